// File: rtl/icache_line_fill.sv
// Instruction-cache refill engine: fetches one cache line as a run of
// incrementing single-word bus reads and returns it with a one-cycle ack.
module icache_line_fill #(
  parameter int ADDR_WIDTH = 32,
  parameter int BUS_WIDTH  = 32,
  parameter int LINE_WIDTH = 128
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  icache2mem_req_i,
  input  logic [ADDR_WIDTH-1:0] icache2mem_addr_i,
  output logic                  mem2icache_ack_o,
  output logic [LINE_WIDTH-1:0] mem2icache_data_o,
  output logic                  bus_req_o,
  output logic [ADDR_WIDTH-1:0] bus_addr_o,
  input  logic                  bus_ack_i,
  input  logic [BUS_WIDTH-1:0]  bus_rdata_i
);

  localparam int BEATS = LINE_WIDTH / BUS_WIDTH;
  localparam int BOFF  = $clog2(BUS_WIDTH / 8);
  localparam int LOFF  = $clog2(LINE_WIDTH / 8);
  localparam int CW    = $clog2(BEATS);
  localparam int BASEW = ADDR_WIDTH - LOFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e           state_r;
  logic [BASEW-1:0] base_r;
  logic [CW-1:0]    beat_r;
  logic [CW-1:0]    beat_nxt_s;
  logic             last_beat_s;
  logic             addr_unused_s;

  function automatic logic [ADDR_WIDTH-1:0] word_addr(input logic [BASEW-1:0] base,
                                                      input logic [CW-1:0]    beat);
    return ADDR_WIDTH'({base, beat}) << BOFF;
  endfunction

  // Offset bits inside the line never influence the refill.
  assign addr_unused_s = ^icache2mem_addr_i[LOFF-1:0];

  // Beat sequencing helpers for the FSM.
  always_comb begin
    beat_nxt_s  = beat_r + CW'(1'b1);
    last_beat_s = (beat_r == CW'(BEATS - 1));
  end

  // Refill FSM; every output is registered here.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r           <= IDLE;
      base_r            <= '0;
      beat_r            <= '0;
      bus_req_o         <= 1'b0;
      bus_addr_o        <= '0;
      mem2icache_ack_o  <= 1'b0;
      mem2icache_data_o <= '0;
    end else begin
      mem2icache_ack_o <= 1'b0;
      case (state_r)
        IDLE: begin
          if (icache2mem_req_i) begin
            base_r     <= icache2mem_addr_i[ADDR_WIDTH-1:LOFF];
            beat_r     <= '0;
            bus_req_o  <= 1'b1;
            bus_addr_o <= word_addr(icache2mem_addr_i[ADDR_WIDTH-1:LOFF], '0);
            state_r    <= FILL;
          end
        end
        FILL: begin
          if (bus_ack_i) begin
            if (!icache2mem_req_i) begin
              bus_req_o <= 1'b0;
              state_r   <= IDLE;
            end else begin
              mem2icache_data_o[int'(beat_r)*BUS_WIDTH +: BUS_WIDTH] <= bus_rdata_i;
              if (last_beat_s) begin
                bus_req_o        <= 1'b0;
                mem2icache_ack_o <= 1'b1;
                state_r          <= DONE;
              end else begin
                beat_r     <= beat_nxt_s;
                bus_addr_o <= word_addr(base_r, beat_nxt_s);
              end
            end
          end else if (!icache2mem_req_i) begin
            // The bus never sees a request withdrawn before its ack.
            state_r <= DRAIN;
          end
        end
        DRAIN: begin
          if (bus_ack_i) begin
            bus_req_o <= 1'b0;
            state_r   <= IDLE;
          end
        end
        DONE: begin
          state_r <= IDLE;
        end
        default: begin
          bus_req_o <= 1'b0;
          state_r   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/icache_line_fill.md
# icache_line_fill

Refill engine between the instruction-cache controller and the word-wide instruction memory bus. On a cache-miss request it fetches one full cache line as a sequence of single-word bus reads, assembles the line, and returns it with a one-cycle acknowledge that the controller uses as its cache write strobe. A request dropped mid-refill (fetch redirect or boot-region PC) aborts the refill cleanly: any outstanding bus beat is drained and no acknowledge is issued.

## Interface

- ADDR_WIDTH, 32, byte address width.
- BUS_WIDTH, 32, bus data width in bits; power of two, ≥ 8.
- LINE_WIDTH, 128, cache line width in bits; power of two, ≥ 2·BUS_WIDTH.
- Derived: BEATS = LINE_WIDTH/BUS_WIDTH; BOFF = log2(BUS_WIDTH/8); LOFF = log2(LINE_WIDTH/8).

- clk_i  in  1  clock, all state on rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- icache2mem_req_i  in  1  refill request from cache controller; level, held until ack or kill.
- icache2mem_addr_i  in  ADDR_WIDTH  miss address; only bits [ADDR_WIDTH-1:LOFF] used.
- mem2icache_ack_o  out  1  refill complete, single-cycle pulse, registered.
- mem2icache_data_o  out  LINE_WIDTH  assembled line; valid while ack high, held until next refill starts.
- bus_req_o  out  1  word read request, registered.
- bus_addr_o  out  ADDR_WIDTH  word address, registered, low BOFF bits zero.
- bus_ack_i  in  1  word read accepted and data valid this cycle; may be combinational on bus_req_o.
- bus_rdata_i  in  BUS_WIDTH  read data, sampled only when bus_req_o & bus_ack_i.

## Operation

- States: IDLE, FILL, DRAIN, DONE.
- IDLE: on icache2mem_req_i=1, latch line base = addr[ADDR_WIDTH-1:LOFF], clear beat counter, set bus_req_o=1 and bus_addr_o={base, 0, BOFF zeros}; go FILL.
- FILL, beat k (0..BEATS-1): bus_addr_o = {base, k, BOFF zeros}; incrementing order, no critical-word-first.
  - bus_ack_i=1 & req=1: store bus_rdata_i into data bits [k·BUS_WIDTH +: BUS_WIDTH]. If k=BEATS-1: bus_req_o←0, go DONE. Else k←k+1, bus_addr_o advances; bus_req_o stays 1 (back-to-back beats).
  - bus_ack_i=1 & req=0: discard data, bus_req_o←0, go IDLE.
  - bus_ack_i=0 & req=0: go DRAIN, bus_req_o stays 1.
  - bus_ack_i=0 & req=1: hold all.
- DRAIN: bus_req_o and bus_addr_o held (bus rule: a raised request is never withdrawn before ack). On bus_ack_i: discard data, bus_req_o←0, go IDLE. icache2mem_req_i ignored.
- DONE: mem2icache_ack_o=1 for exactly this cycle; go IDLE unconditionally. icache2mem_req_i, still high this cycle, does not start a new refill.
- A new request is accepted only in IDLE; a re-raised request during DRAIN waits until IDLE.
- bus_ack_i while bus_req_o=0 is ignored.
- Beat counter width log2(BEATS); wraps only via reset to 0 at refill start.
- Partial line data from an aborted refill is never acknowledged; mem2icache_data_o contents after abort are don't-care.

## Timing

- Reset (async assert): state IDLE, bus_req_o=0, bus_addr_o=0, mem2icache_ack_o=0, mem2icache_data_o=0, beat counter 0. Reset mid-refill abandons the beat with no ack; deassertion is synchronised externally.
- Zero-wait bus (ack in the same cycle as bus_req_o): req seen in cycle 0, beats in cycles 1..BEATS, ack_o in cycle BEATS+1. Default config: ack in cycle 5.
- Each bus wait cycle adds one cycle. No idle cycle between beats.
- Minimum spacing between two acks: BEATS+2 cycles (DONE→IDLE→FILL).
- Kill latency: with no outstanding beat, the engine is back in IDLE one cycle after req drops. Otherwise it returns to IDLE the cycle after the outstanding beat's bus_ack_i.

## Test plan

- Basic refill, zero-wait bus, addr 0x8000_1234: bus addresses 0x8000_1230/34/38/3C in cycles 1–4. Data 0x11111111..0x44444444 produces line 0x44444444_33333333_22222222_11111111. Ack pulse in cycle 5, exactly one cycle.
- Wait states: bus_ack_i delayed 2 cycles on every beat. Addresses hold during waits, ack in cycle 13, line correct.
- Kill with outstanding beat: req drops in cycle 2 with beat 1 unacked. bus_req_o stays 1 at 0x…34 until ack in cycle 6, then 0. Never any ack_o. Next request starts cleanly at beat 0.
- Kill coincident with beat ack: req=0 & bus_ack_i=1 on beat 2. bus_req_o=0 next cycle, IDLE, no ack.
- Back-to-back misses: req held through DONE, then re-raised with new addr 0x0000_0040. Exactly one ack for the first refill; the second refill starts at 0x40 and acks BEATS+2 cycles after the first.
- Async reset asserted mid-FILL (between edges): all outputs 0 immediately. After release, a fresh refill completes correctly.
